control_unit: RTL

- Multicycle control FSM that sits directly upstream of the 16-bit ALU and register file in the CPU datapath.
- Fetches 16-bit instructions from a synchronous instruction memory and decodes them.
- Sequences register-file read/write addresses, data-memory strobes and the 3-bit ALU function select (`ALU_Sel`) for each instruction.

---
 rtl/control_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/control_unit.sv
// control_unit -- multicycle fetch/decode/execute controller for the 16-bit
// ALU + register file datapath.
//
// An instruction is fetched from a registered instruction memory (read data
// appears the cycle after PC_Out is presented). It is captured into IR in
// DECODE, and then the execute states drive the register file, data memory
// and ALU controls. All control outputs are Moore outputs, decoded only from
// the current state and IR.
//
// Optional feature macro: CU_JUMP_EN
//   defined   : opcode F is JMP (DECODE -> JUMP, PC <= IR[PC_W-1:0])
//   undefined : opcode F is illegal; the JUMP state does not exist
//
// Ports:
//   Clk, Reset_n           clock, async active-low reset
//   Instr_In[15:0]         instruction memory read data
//   PC_Out[PC_W-1:0]       program counter / instruction address
//   IR_Out[15:0]           instruction register
//   State_Out[3:0]         current state encoding (debug)
//   D_Addr[7:0]            data memory address
//   D_Rd, D_Wr             data memory read / write strobes
//   RF_s                   RF write-data select (0 ALU, 1 data memory)
//   RF_W_en, RF_W_Addr     RF write enable / address
//   RF_Ra_Addr, RF_Rb_Addr RF read port addresses
//   ALU_Sel[2:0]           ALU function select
//   Halted                 high while in HALT
//   Illegal                sticky undefined-opcode flag

module control_unit #(
  parameter int PC_W = 7
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [15:0]     Instr_In,
  output logic [PC_W-1:0] PC_Out,
  output logic [15:0]     IR_Out,
  output logic [3:0]      State_Out,
  output logic [7:0]      D_Addr,
  output logic            D_Rd,
  output logic            D_Wr,
  output logic            RF_s,
  output logic            RF_W_en,
  output logic [3:0]      RF_W_Addr,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic [2:0]      ALU_Sel,
  output logic            Halted,
  output logic            Illegal
);

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_LOAD_A = 4'd3;
  localparam logic [3:0] S_LOAD_B = 4'd4;
  localparam logic [3:0] S_STORE  = 4'd5;
  localparam logic [3:0] S_ALU_OP = 4'd6;
  localparam logic [3:0] S_HALT   = 4'd7;
`ifdef CU_JUMP_EN
  localparam logic [3:0] S_JUMP   = 4'd8;
`endif

  localparam logic [3:0] OP_NOOP  = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_INC   = 4'h9;
  localparam logic [3:0] OP_HALT  = 4'hA;
`ifdef CU_JUMP_EN
  localparam logic [3:0] OP_JMP   = 4'hF;
`endif

  logic [3:0]      state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic            illegal;
  logic [3:0]      dec_op;
  logic            dec_illegal;

  // Opcode being decoded comes straight from memory; IR is only loaded on
  // the DECODE edge.
  assign dec_op = Instr_In[15:12];

  always_comb begin
    dec_illegal = (dec_op > OP_HALT);
`ifdef CU_JUMP_EN
    if (dec_op == OP_JMP) dec_illegal = 1'b0;
`endif
  end

  // ---------------- state register ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= S_INIT;
    else          state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:   state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (dec_op == OP_NOOP)                          state_nxt = S_FETCH;
        else if (dec_op == OP_LOAD)                     state_nxt = S_LOAD_A;
        else if (dec_op == OP_STORE)                    state_nxt = S_STORE;
        else if (dec_op >= OP_ADD && dec_op <= OP_INC)  state_nxt = S_ALU_OP;
`ifdef CU_JUMP_EN
        else if (dec_op == OP_JMP)                      state_nxt = S_JUMP;
`endif
        else                                            state_nxt = S_HALT;
      end
      S_LOAD_A: state_nxt = S_LOAD_B;
      S_LOAD_B: state_nxt = S_FETCH;
      S_STORE:  state_nxt = S_FETCH;
      S_ALU_OP: state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
`ifdef CU_JUMP_EN
      S_JUMP:   state_nxt = S_FETCH;
`endif
      default:  state_nxt = S_INIT;
    endcase
  end

  // ---------------- PC / IR / sticky illegal flag ----------------
  // PC advances once per fetched instruction (in DECODE), including HALT
  // and illegal opcodes; a jump then overwrites it in the JUMP state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc      <= '0;
      ir      <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        S_INIT: pc <= '0;
        S_DECODE: begin
          ir <= Instr_In;
          pc <= pc + PC_W'(1);
          if (dec_illegal) illegal <= 1'b1;
        end
`ifdef CU_JUMP_EN
        S_JUMP: pc <= ir[PC_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  // ---------------- Moore output decode ----------------
  always_comb begin
    D_Addr     = '0;
    D_Rd       = 1'b0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_en    = 1'b0;
    RF_W_Addr  = '0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_Sel    = '0;
    Halted     = 1'b0;
    case (state)
      S_LOAD_A: begin
        D_Addr = ir[7:0];
        D_Rd   = 1'b1;
      end
      S_LOAD_B: begin
        D_Addr    = ir[7:0];
        RF_s      = 1'b1;
        RF_W_en   = 1'b1;
        RF_W_Addr = ir[11:8];
      end
      S_STORE: begin
        D_Addr     = ir[7:0];
        RF_Ra_Addr = ir[11:8];
        D_Wr       = 1'b1;
      end
      S_ALU_OP: begin
        RF_Ra_Addr = ir[7:4];
        RF_Rb_Addr = ir[3:0];
        // opcodes 3..9 map to selects 1..7; mod-8 subtract on the low
        // three opcode bits gives the same result (9 -> 1 - 2 = 7)
        ALU_Sel    = ir[14:12] - 3'd2;
        RF_W_en    = 1'b1;
        RF_W_Addr  = ir[11:8];
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  assign PC_Out    = pc;
  assign IR_Out    = ir;
  assign State_Out = state;
  assign Illegal   = illegal;

endmodule
